// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit: MULT/MULTU/DIV/DIVU with HI/LO registers.
// One shift-add (mul) or restoring shift-subtract (div) step per cycle.
module mul_div_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         div0,
  output logic [N-1:0] HI,
  output logic [N-1:0] LO
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d, araw_q, araw_d;
  logic            sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [N-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic            done_q, done_d, div0_q, div0_d;

  logic            a_neg, b_neg;
  logic [N-1:0]    a_abs, b_abs;
  logic [N:0]      mul_sum, rem_sh, diff;
  logic [2*N-1:0]  mul_nxt, div_nxt, prod_fix;
  logic [N-1:0]    quot_fix, rem_fix;

  // Only the signed ops (op[0]==0) take magnitudes; unsigned ops pass raw values.
  assign a_neg = ~op[0] & A[N-1];
  assign b_neg = ~op[0] & B[N-1];
  assign a_abs = a_neg ? (~A + 1'b1) : A;
  assign b_abs = b_neg ? (~B + 1'b1) : B;

  // Multiply: {hi,lo} accumulator with the multiplier in lo, consumed LSB first.
  assign mul_sum = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, a_q} : {(N+1){1'b0}});
  assign mul_nxt = {mul_sum, acc_q[N-1:1]};

  // Divide: {rem,quot}; the shifted remainder needs N+1 bits before the trial subtract.
  assign rem_sh  = {acc_q[2*N-1:N], acc_q[N-1]};
  assign diff    = rem_sh - {1'b0, b_q};
  assign div_nxt = diff[N] ? {rem_sh[N-1:0], acc_q[N-2:0], 1'b0}
                           : {diff[N-1:0],   acc_q[N-2:0], 1'b1};

  assign prod_fix = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
  assign quot_fix = (sa_q ^ sb_q) ? (~acc_q[N-1:0] + 1'b1) : acc_q[N-1:0];
  assign rem_fix  = sa_q ? (~acc_q[2*N-1:N] + 1'b1) : acc_q[2*N-1:N];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    araw_d  = araw_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div0_d  = div0_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          op_d    = op;
          a_d     = a_abs;
          b_d     = b_abs;
          araw_d  = A;
          sa_d    = a_neg;
          sb_d    = b_neg;
          div0_d  = 1'b0;
          cnt_d   = '0;
          acc_d   = op[1] ? {{N{1'b0}}, a_abs} : {{N{1'b0}}, b_abs};
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      RUN: begin
        acc_d = op_q[1] ? div_nxt : mul_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N-1)) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (op_q[1]) begin
          if (b_q == '0) begin
            hi_d   = araw_q;
            lo_d   = {N{1'b1}};
            div0_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      araw_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      araw_q  <= araw_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign div0 = div0_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit for the MIPS pipeline execute stage. Implements MULT, MULTU, DIV and DIVU, which the single-cycle ALU does not cover.
- Holds results in HI/LO registers and supports MTHI/MTLO writes.
- Iterative design: one shift-add or shift-subtract step per cycle. The hazard unit stalls MFHI/MFLO and new mul/div ops while busy=1.

Parameters:
- N, 32, operand width; HI and LO are each N bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; accepted only when busy=0.
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- A  input  N  multiplicand or dividend (rs).
- B  input  N  multiplier or divisor (rt).
- hi_we  input  1  MTHI write strobe.
- lo_we  input  1  MTLO write strobe.
- wdata  input  N  data for MTHI/MTLO.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: HI/LO have just been updated by a mul/div.
- div0  output  1  last completed division had B=0; sticky until next accepted start.
- HI  output  N  high product, or remainder.
- LO  output  N  low product, or quotient.

Behaviour:
- **Reset.** While reset=1 (asynchronous):
  - busy=0, done=0, div0=0, HI=0, LO=0.
  - Iteration counter and working registers are cleared.
  - Reset mid-operation aborts the operation. No done pulse follows, and HI/LO read 0.
- **States:** IDLE, RUN, FINISH.
- **IDLE.**
  - On a clk edge with start=1: latch op; latch |A| and |B| for signed ops (raw values for unsigned ops); latch result signs; clear div0; counter=0; go to RUN. busy=1 from that edge.
- **RUN.** One iteration per cycle, N iterations total (counter 0..N-1).
  - Multiply: 2N-bit accumulator, shift-add, LSB first.
  - Divide: restoring. Shift {rem, quot} left one bit; trial-subtract the divisor using an N+1-bit difference; keep it if non-negative and set the quotient bit.
  - After iteration N-1, go to FINISH.
- **FINISH.** Lasts one cycle.
  - Apply sign correction:
    - product negated if sign(A) XOR sign(B) (signed mul only);
    - quotient negated if sign(A) XOR sign(B);
    - remainder takes the sign of A.
  - Write HI/LO on the edge leaving FINISH. On that same edge busy drops to 0 and done rises for exactly one cycle. Return to IDLE.
- **Latency.** Start accepted at edge k means HI/LO are valid and done=1 after edge k+N+1. busy=1 for cycles k..k+N (N+1 cycles).
- **start while busy=1:** ignored. Not queued, no effect on the current operation.
- **start on the same cycle done=1:** accepted normally (busy=0 at that point).
- **Divide by zero (B=0, DIV or DIVU):**
  - Same latency as a normal divide.
  - LO={N{1}}, HI=A (original, unsigned view); div0=1.
  - No exception raised.
- **Signed overflow** (DIV with A=0x80000000, B=0xFFFFFFFF): LO=0x80000000, HI=0, div0=0.
- **Products:** MULT gives the 2N-bit two's-complement product; MULTU gives the unsigned product. HI=upper N bits, LO=lower N bits.
- **HI/LO writes (MTHI/MTLO):**
  - hi_we/lo_we are honoured only when busy=0 and start=0. They write wdata on the edge and are visible the next cycle.
  - Both asserted together write both registers.
  - Ignored while busy=1.
  - If start=1 on the same edge, start wins and the write is dropped.
- **HI/LO hold:** hold their value at all times except the FINISH-exit edge and honoured MT writes. They are not disturbed during RUN.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> busy for 33 cycles; done pulse after edge k+33; HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFD(-3), B=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIV A=0xFFFFFFF9(-7), B=0x00000002 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=100, B=7 -> LO=14, HI=2.
- DIVU A=0x12345678, B=0 -> LO=0xFFFFFFFF, HI=0x12345678, div0=1. A following MULTU start clears div0.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. Second start at cycle k+5 with different operands is ignored; result unchanged.
- Reset asserted asynchronously at cycle k+10 of a MULTU -> busy=0, HI=LO=0 immediately, no done pulse. After reset, lo_we=1 with wdata=0xA5A5A5A5 -> LO=0xA5A5A5A5; hi_we during busy -> HI unchanged.
